lane_vrf_write_arbiter: RTL and testbench

Lane-local stage directly downstream of the stage-3 VRF write queue. It merges the stage-3 write request with the cross-lane write request, arbitrates them round-robin into a single registered VRF bank write port, and tracks in-flight writes per instruction index. The per-instruction outstanding vector feeds the lane's instruction-retire logic.

---
 rtl/lane_vrf_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_lane_vrf_write_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lane_vrf_write_arbiter.sv
// lane_vrf_write_arbiter: merges the stage-3 and cross-lane VRF write requests
// round-robin into one registered VRF bank write port, and tracks in-flight
// writes per instruction index for the retire logic.
//
// state | meaning
// rr_q=0 | stage-3 port wins the next two-way contention
// rr_q=1 | cross-lane port wins the next two-way contention
module lane_vrf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int VD_WIDTH   = 5,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  s3_ready,
    input  logic                  s3_valid,
    input  logic [VD_WIDTH-1:0]   s3_vd,
    input  logic [MASK_WIDTH-1:0] s3_mask,
    input  logic [DATA_WIDTH-1:0] s3_data,
    input  logic                  s3_last,
    input  logic [2:0]            s3_instructionIndex,
    output logic                  cw_ready,
    input  logic                  cw_valid,
    input  logic [VD_WIDTH-1:0]   cw_vd,
    input  logic [MASK_WIDTH-1:0] cw_mask,
    input  logic [DATA_WIDTH-1:0] cw_data,
    input  logic                  cw_last,
    input  logic [2:0]            cw_instructionIndex,
    input  logic                  vrfWrite_ready,
    output logic                  vrfWrite_valid,
    output logic [VD_WIDTH-1:0]   vrfWrite_vd,
    output logic [MASK_WIDTH-1:0] vrfWrite_mask,
    output logic [DATA_WIDTH-1:0] vrfWrite_data,
    output logic                  vrfWrite_last,
    output logic [2:0]            vrfWrite_instructionIndex,
    output logic [7:0]            writeOutstanding,
    output logic [7:0]            instructionWriteDone
);

    localparam int NIDX = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  valid_q, valid_d;
    logic [VD_WIDTH-1:0]   vd_q, vd_d;
    logic [MASK_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [2:0]            idx_q, idx_d;
    logic                  rr_q, rr_d;
    logic [7:0]            done_q, done_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NIDX];
    logic [CNT_WIDTH-1:0]  cnt_d [NIDX];

    logic commit, loadable, elig_s3, elig_cw, gnt_s3, gnt_cw;

    // Eligibility and round-robin grant; only eligible ports compete.
    always_comb begin
        commit   = valid_q & vrfWrite_ready;
        loadable = ~valid_q | vrfWrite_ready;
        elig_s3  = s3_valid & loadable & (cnt_q[s3_instructionIndex] != CNT_MAX) & reset;
        elig_cw  = cw_valid & loadable & (cnt_q[cw_instructionIndex] != CNT_MAX) & reset;
        gnt_s3   = elig_s3 & (~elig_cw | ~rr_q);
        gnt_cw   = elig_cw & (~elig_s3 | rr_q);
    end

    assign s3_ready = gnt_s3;
    assign cw_ready = gnt_cw;

    // Next-state for output register, pointer, counters and done pulses.
    always_comb begin
        valid_d = valid_q;
        vd_d    = vd_q;
        mask_d  = mask_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        if (gnt_s3) begin
            valid_d = 1'b1;
            vd_d    = s3_vd;
            mask_d  = s3_mask;
            data_d  = s3_data;
            last_d  = s3_last;
            idx_d   = s3_instructionIndex;
            rr_d    = 1'b1;
        end else if (gnt_cw) begin
            valid_d = 1'b1;
            vd_d    = cw_vd;
            mask_d  = cw_mask;
            data_d  = cw_data;
            last_d  = cw_last;
            idx_d   = cw_instructionIndex;
            rr_d    = 1'b0;
        end else if (commit) begin
            valid_d = 1'b0;
        end
        for (int i = 0; i < NIDX; i++) begin
            logic inc, dec;
            inc = (gnt_s3 & (s3_instructionIndex == 3'(i))) |
                  (gnt_cw & (cw_instructionIndex == 3'(i)));
            dec = commit & (idx_q == 3'(i));
            cnt_d[i] = cnt_q[i];
            if (inc & ~dec)
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (dec & ~inc)
                cnt_d[i] = cnt_q[i] - 1'b1;
            done_d[i] = commit & last_q & (idx_q == 3'(i));
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            vd_q    <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            rr_q    <= 1'b0;
            done_q  <= '0;
            for (int i = 0; i < NIDX; i++) cnt_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            vd_q    <= vd_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            for (int i = 0; i < NIDX; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Outstanding flags straight from the counters.
    always_comb begin
        for (int i = 0; i < NIDX; i++) writeOutstanding[i] = |cnt_q[i];
    end

    assign vrfWrite_valid            = valid_q;
    assign vrfWrite_vd               = vd_q;
    assign vrfWrite_mask             = mask_q;
    assign vrfWrite_data             = data_q;
    assign vrfWrite_last             = last_q;
    assign vrfWrite_instructionIndex = idx_q;
    assign instructionWriteDone      = done_q;

    // A committing write always has a matching nonzero counter.
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        (valid_q && vrfWrite_ready) |-> (cnt_q[idx_q] != '0));

endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// Randomized scoreboard bench for lane_vrf_write_arbiter.
module tb_lane_vrf_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        s3_ready, s3_valid, s3_last;
    logic [4:0]  s3_vd;
    logic [3:0]  s3_mask;
    logic [31:0] s3_data;
    logic [2:0]  s3_instructionIndex;
    logic        cw_ready, cw_valid, cw_last;
    logic [4:0]  cw_vd;
    logic [3:0]  cw_mask;
    logic [31:0] cw_data;
    logic [2:0]  cw_instructionIndex;
    logic        vrfWrite_ready, vrfWrite_valid, vrfWrite_last;
    logic [4:0]  vrfWrite_vd;
    logic [3:0]  vrfWrite_mask;
    logic [31:0] vrfWrite_data;
    logic [2:0]  vrfWrite_instructionIndex;
    logic [7:0]  writeOutstanding, instructionWriteDone;

    always #5 clock = ~clock;

    lane_vrf_write_arbiter dut (
        .clock(clock), .reset(reset),
        .s3_ready(s3_ready), .s3_valid(s3_valid), .s3_vd(s3_vd), .s3_mask(s3_mask),
        .s3_data(s3_data), .s3_last(s3_last), .s3_instructionIndex(s3_instructionIndex),
        .cw_ready(cw_ready), .cw_valid(cw_valid), .cw_vd(cw_vd), .cw_mask(cw_mask),
        .cw_data(cw_data), .cw_last(cw_last), .cw_instructionIndex(cw_instructionIndex),
        .vrfWrite_ready(vrfWrite_ready), .vrfWrite_valid(vrfWrite_valid),
        .vrfWrite_vd(vrfWrite_vd), .vrfWrite_mask(vrfWrite_mask),
        .vrfWrite_data(vrfWrite_data), .vrfWrite_last(vrfWrite_last),
        .vrfWrite_instructionIndex(vrfWrite_instructionIndex),
        .writeOutstanding(writeOutstanding), .instructionWriteDone(instructionWriteDone)
    );

    // payload packed as {vd, mask, data, last, idx}
    typedef logic [44:0] pay_t;

    pay_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: output slot occupancy, per-index in-flight counts
    bit   m_occ;
    pay_t m_cur;
    int   m_cnt[8];
    int   m_prio;
    logic [7:0] m_done;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_occ  = 1'b0;
        m_cur  = '0;
        m_prio = 0;
        m_done = '0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    endfunction

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge clock) begin
        if (reset && vrfWrite_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 64'(vrfWrite_valid), 64'd0);
            end else begin
                chk("vrf_payload", 64'({vrfWrite_vd, vrfWrite_mask, vrfWrite_data,
                                        vrfWrite_last, vrfWrite_instructionIndex}), 64'(sb[0]));
                if (vrfWrite_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int   mode, imax;
        bit   e_s3, e_cw, g_s3, g_cw, loadable, commit;
        pay_t p_s3, p_cw;
        logic [7:0] exp_out;

        reset = 1'b0;
        s3_valid = 0; s3_vd = 0; s3_mask = 0; s3_data = 0; s3_last = 0; s3_instructionIndex = 0;
        cw_valid = 0; cw_vd = 0; cw_mask = 0; cw_data = 0; cw_last = 0; cw_instructionIndex = 0;
        vrfWrite_ready = 0;
        model_reset();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            mode = (cyc / 400) % 4;
            imax = (mode == 3) ? 1 : 7;
            reset = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 299) != 0);
            case (mode)
                0: begin
                    s3_valid = 1'($urandom_range(0, 1));
                    cw_valid = 1'($urandom_range(0, 1));
                    vrfWrite_ready = 1'($urandom_range(0, 9) < 7);
                end
                1: begin
                    s3_valid = 1'b1;
                    cw_valid = 1'b1;
                    vrfWrite_ready = 1'b1;
                end
                2: begin
                    s3_valid = 1'($urandom_range(0, 9) < 8);
                    cw_valid = 1'($urandom_range(0, 9) < 8);
                    vrfWrite_ready = 1'($urandom_range(0, 9) < 2);
                end
                default: begin
                    s3_valid = 1'($urandom_range(0, 1));
                    cw_valid = 1'($urandom_range(0, 1));
                    vrfWrite_ready = 1'($urandom_range(0, 9) < 9);
                end
            endcase
            s3_vd   = 5'($urandom);
            s3_mask = 4'($urandom);
            s3_data = $urandom;
            s3_last = 1'($urandom_range(0, 2) == 0);
            s3_instructionIndex = 3'($urandom_range(0, imax));
            cw_vd   = 5'($urandom);
            cw_mask = 4'($urandom);
            cw_data = $urandom;
            cw_last = 1'($urandom_range(0, 2) == 0);
            cw_instructionIndex = 3'($urandom_range(0, imax));

            @(negedge clock);

            // outputs reflecting the previous edge
            chk("vrf_valid", 64'(vrfWrite_valid), 64'(m_occ));
            for (int i = 0; i < 8; i++) exp_out[i] = (m_cnt[i] != 0);
            chk("write_outstanding", 64'(writeOutstanding), 64'(exp_out));
            chk("write_done", 64'(instructionWriteDone), 64'(m_done));
            if (cyc == 2)
                chk("reset_payload", 64'({vrfWrite_vd, vrfWrite_mask, vrfWrite_data,
                                          vrfWrite_last, vrfWrite_instructionIndex}), 64'd0);

            // expected grant for the coming edge
            p_s3 = {s3_vd, s3_mask, s3_data, s3_last, s3_instructionIndex};
            p_cw = {cw_vd, cw_mask, cw_data, cw_last, cw_instructionIndex};
            loadable = !m_occ || vrfWrite_ready;
            e_s3 = reset && s3_valid && loadable && (m_cnt[s3_instructionIndex] < 7);
            e_cw = reset && cw_valid && loadable && (m_cnt[cw_instructionIndex] < 7);
            g_s3 = e_s3 && (!e_cw || m_prio == 0);
            g_cw = e_cw && (!e_s3 || m_prio == 1);
            chk("s3_ready", 64'(s3_ready), 64'(g_s3));
            chk("cw_ready", 64'(cw_ready), 64'(g_cw));

            if (!reset) begin
                sb.delete();
                model_reset();
            end else begin
                commit = m_occ && vrfWrite_ready;
                m_done = '0;
                if (commit) begin
                    m_cnt[m_cur[2:0]] -= 1;
                    if (m_cur[3]) m_done[m_cur[2:0]] = 1'b1;
                    m_occ = 1'b0;
                end
                if (g_s3) begin
                    sb.push_back(p_s3);
                    m_cnt[s3_instructionIndex] += 1;
                    m_cur = p_s3;
                    m_occ = 1'b1;
                    m_prio = 1;
                end else if (g_cw) begin
                    sb.push_back(p_cw);
                    m_cnt[cw_instructionIndex] += 1;
                    m_cur = p_cw;
                    m_occ = 1'b1;
                    m_prio = 0;
                end
            end

            @(posedge clock);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
